// File: rtl/ps2_key_event_fifo_if.sv
// ps2_key_event_fifo_if: byte-in / key-event-out bus between the PS/2 front end and the keyboard port.
interface ps2_key_event_fifo_if #(
    parameter int ADDR_W = 3
);
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rd_en;
    logic            ovf_clr;
    logic [9:0]      rd_data;
    logic            empty;
    logic            full;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic [7:0]      last_code;
    logic            key_down;

    modport master (
        output rx_data, rx_valid, rd_en, ovf_clr,
        input  rd_data, empty, full, count, overflow, last_code, key_down
    );

    modport slave (
        input  rx_data, rx_valid, rd_en, ovf_clr,
        output rd_data, empty, full, count, overflow, last_code, key_down
    );
endinterface

// File: rtl/ps2_key_event_fifo.sv
// ps2_key_event_fifo: scan-code set 2 prefix decoder feeding a FWFT event FIFO,
// plus a self-clearing "last key held" register.
module ps2_key_event_fifo #(
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 3,
    parameter int HOLD_CYCLES = 2500000,
    parameter int HOLD_W      = 22
) (
    input logic                inclock,
    input logic                resetn,
    ps2_key_event_fifo_if.slave bus
);
    // bit 0 = extended prefix seen, bit 1 = break prefix seen
    typedef enum logic [1:0] {IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXT_BRK = 2'd3} state_t;

    state_t              state_q, state_d;
    logic [9:0]          mem_q [DEPTH];
    logic [9:0]          mem_d [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          last_q, last_d;
    logic [HOLD_W-1:0]   hold_q, hold_d, hold_inc;
    logic                ev_valid, pop, push_ok, full, empty;
    logic [9:0]          ev_data;

    assign full  = count_q == (ADDR_W+1)'(DEPTH);
    assign empty = count_q == '0;
    assign pop   = bus.rd_en && !empty;
    assign push_ok = ev_valid && (!full || pop);
    assign hold_inc = &hold_q ? hold_q : hold_q + HOLD_W'(1);

    always_comb begin
        state_d  = state_q;
        ev_valid = 1'b0;
        ev_data  = {state_q[0], state_q[1], bus.rx_data};
        if (bus.rx_valid) begin
            if (bus.rx_data == 8'hE0) state_d = state_t'(state_q | EXT);
            else if (bus.rx_data == 8'hF0) state_d = state_t'(state_q | BRK);
            else begin
                ev_valid = 1'b1;
                state_d  = IDLE;
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = ev_data;
        wr_ptr_d   = push_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d    = count_q + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop);
        overflow_d = (ev_valid && !push_ok) ? 1'b1 : bus.ovf_clr ? 1'b0 : overflow_q;
    end

    // a make in the same cycle as expiry takes priority over the clear
    always_comb begin
        last_d = last_q;
        hold_d = hold_inc;
        if (ev_valid && !ev_data[8]) begin
            last_d = ev_data[7:0];
            hold_d = '0;
        end else if (ev_valid && ev_data[7:0] == last_q) last_d = 8'h00;
        else if (HOLD_CYCLES != 0 && hold_inc >= HOLD_W'(HOLD_CYCLES)) last_d = 8'h00;
    end

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            last_q     <= 8'h00;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            last_q     <= last_d;
            hold_q     <= hold_d;
        end
    end

    assign bus.rd_data   = mem_q[rd_ptr_q];
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.last_code = last_q;
    assign bus.key_down  = last_q != 8'h00;
endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// tb_ps2_key_event_fifo: random and directed byte streams checked against a queue-based model;
// instance a is DEPTH=4/HOLD=10, instance b is DEPTH=8 with auto-clear disabled.
module tb_ps2_key_event_fifo;
    logic inclock = 1'b0;
    logic resetn  = 1'b0;
    always #5 inclock = ~inclock;

    ps2_key_event_fifo_if #(.ADDR_W(2)) ia ();
    ps2_key_event_fifo_if #(.ADDR_W(3)) ib ();

    ps2_key_event_fifo #(.DEPTH(4), .ADDR_W(2), .HOLD_CYCLES(10), .HOLD_W(22)) dut_a (
        .inclock(inclock), .resetn(resetn), .bus(ia));
    ps2_key_event_fifo #(.DEPTH(8), .ADDR_W(3), .HOLD_CYCLES(0), .HOLD_W(22)) dut_b (
        .inclock(inclock), .resetn(resetn), .bus(ib));

    int n_chk  = 0;
    int n_pass = 0;

    logic [9:0] mq[$];
    bit         pe, pb, movf;
    logic [7:0] lc, lcb;
    int         idle;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic c);
        ia.rx_valid = v; ia.rx_data = d; ia.rd_en = r; ia.ovf_clr = c;
        ib.rx_valid = v; ib.rx_data = d; ib.rd_en = r; ib.ovf_clr = c;
    endtask

    task automatic model(input logic v, input logic [7:0] d, input logic r, input logic c);
        bit has_ev, pop, drop;
        logic [9:0] ev;
        has_ev = 0; drop = 0; ev = '0;
        if (v) begin
            if (d == 8'hE0) pe = 1;
            else if (d == 8'hF0) pb = 1;
            else begin
                has_ev = 1; ev = {pe, pb, d}; pe = 0; pb = 0;
            end
        end
        pop = r && mq.size() > 0;
        if (pop) void'(mq.pop_front());
        if (has_ev) begin
            if (mq.size() < 4) mq.push_back(ev);
            else drop = 1;
        end
        movf = drop ? 1'b1 : c ? 1'b0 : movf;
        if (has_ev && !ev[8]) begin
            lc = d; lcb = d; idle = 0;
        end else begin
            idle++;
            if (has_ev && ev[7:0] == lc) lc = 8'h00;
            else if (idle >= 10) lc = 8'h00;
            if (has_ev && ev[7:0] == lcb) lcb = 8'h00;
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
        drive(v, d, r, c);
        @(posedge inclock);
        model(v, d, r, c);
        #1;
        check("count", 32'(ia.count), 32'(mq.size()));
        check("empty", 32'(ia.empty), 32'(mq.size() == 0));
        check("full", 32'(ia.full), 32'(mq.size() == 4));
        check("overflow", 32'(ia.overflow), 32'(movf));
        check("last_code", 32'(ia.last_code), 32'(lc));
        check("key_down", 32'(ia.key_down), 32'(lc != 8'h00));
        check("last_code_nohold", 32'(ib.last_code), 32'(lcb));
        if (mq.size() > 0) check("rd_data", 32'(ia.rd_data), 32'(mq[0]));
    endtask

    task automatic do_reset();
        drive(0, 8'h00, 0, 0);
        resetn = 1'b0;
        #3;
        check("rst_count", 32'(ia.count), 0);
        check("rst_empty", 32'(ia.empty), 1);
        check("rst_full", 32'(ia.full), 0);
        check("rst_overflow", 32'(ia.overflow), 0);
        check("rst_last_code", 32'(ia.last_code), 0);
        check("rst_key_down", 32'(ia.key_down), 0);
        check("rst_rd_data", 32'(ia.rd_data), 0);
        check("rst_b_count", 32'(ib.count), 0);
        mq.delete(); pe = 0; pb = 0; movf = 0; lc = 0; lcb = 0; idle = 0;
        @(negedge inclock);
        resetn = 1'b1;
    endtask

    function automatic logic [7:0] rnd_byte();
        int p;
        p = $urandom_range(0, 99);
        if (p < 20) return 8'hE0;
        if (p < 40) return 8'hF0;
        if (p < 60) return 8'h1C;
        if (p < 75) return 8'h75;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        do_reset();
        step(1, 8'h1C, 0, 0);
        step(0, 8'h00, 1, 0);
        step(1, 8'hE0, 0, 0);
        step(1, 8'h75, 0, 0);
        step(1, 8'hE0, 0, 0);
        step(1, 8'hF0, 0, 0);
        step(1, 8'h75, 1, 0);
        step(0, 8'h00, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 8'h10 + 8'(i), 0, 0);
        step(1, 8'h30, 1, 0);
        step(0, 8'h00, 0, 1);
        step(1, 8'h31, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0);
        step(1, 8'h1C, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 8'h00, 0, 0);
        step(1, 8'hF0, 0, 0);
        do_reset();
        step(1, 8'h1C, 0, 0);
        step(1, 8'hF0, 0, 0);
        step(1, 8'hE0, 0, 0);
        step(1, 8'hE0, 0, 0);
        step(1, 8'h1C, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0)
                for (int k = 0; k < 12; k++) step(0, 8'h00, 0, 0);
            step($urandom_range(0, 99) < 60, rnd_byte(), $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 4);
            if (i == 1500) do_reset();
        end
        drive(0, 8'h00, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ps2_key_event_fifo.md
# ps2_key_event_fifo

Parametrised PS/2 keyboard front end that sits between the PS/2 controller's received-byte strobe and the processor's memory-mapped keyboard port. It decodes the scan-code set 2 prefixes (0xE0 extended, 0xF0 break) into single key events, buffers them in a first-word-fall-through FIFO of configurable depth, and keeps a "last key held" register that clears itself after a programmable idle time. It supersedes the single-register, no-prefix, non-buffered keyboard capture.

## Interface
- DEPTH, 8, FIFO entries; power of two, minimum 2
- ADDR_W, 3, log2(DEPTH)
- HOLD_CYCLES, 2500000, idle cycles after last make before last_code clears; 0 disables auto-clear
- HOLD_W, 22, width of hold counter; must hold HOLD_CYCLES
- inclock  in  1  system clock
- resetn  in  1  reset; asynchronous, active-low
- rx_data  in  8  byte from PS/2 controller
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rd_en  in  1  pop head event (ignored when empty)
- ovf_clr  in  1  clears overflow flag
- rd_data  out  10  head event {ext, brk, code[7:0]}; valid when empty=0
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- count  out  ADDR_W+1  entries held, 0..DEPTH
- overflow  out  1  sticky; an event was dropped
- last_code  out  8  code of most recent make event, or 0x00
- key_down  out  1  last_code != 0

## Operation
- Prefix decoder, states IDLE, EXT, BRK, EXT_BRK; advances only on rx_valid.
  - IDLE: 0xE0 -> EXT; 0xF0 -> BRK; other -> emit {0,0,byte}, stay IDLE.
  - EXT: 0xF0 -> EXT_BRK; 0xE0 -> stay EXT; other -> emit {1,0,byte}, -> IDLE.
  - BRK: 0xF0/0xE0 -> stay BRK, 0xE0 additionally sets ext (-> EXT_BRK); other -> emit {0,1,byte}, -> IDLE.
  - EXT_BRK: 0xE0/0xF0 -> stay; other -> emit {1,1,byte}, -> IDLE.
  - All other bytes (0xAA, 0xFA, 0xE1, 0xFE, ...) are emitted as ordinary codes.
- FIFO: emitted event is written at wr_ptr; rd_en with empty=0 advances rd_ptr. Pointers ADDR_W bits, wrap modulo DEPTH.
  - Push while full with no pop: event dropped, overflow set, FIFO unchanged.
  - Push and pop same cycle when full: both proceed, count stays DEPTH, no overflow.
  - Push and pop same cycle when empty: pop ignored, push accepted, count -> 1.
  - rd_en while empty: no effect.
  - overflow: set by drop, cleared by ovf_clr; set wins if both in the same cycle.
- Last-key register: make event (brk=0) loads last_code <= code and zeroes hold counter. Break event whose code equals last_code clears last_code to 0x00. Otherwise the hold counter increments each cycle, saturating; when it reaches HOLD_CYCLES (HOLD_CYCLES != 0) last_code clears to 0x00. Make event in the same cycle as expiry wins.

## Timing
- Reset (resetn low, asynchronous): decoder IDLE, pointers 0, count 0, empty 1, full 0, overflow 0, last_code 0x00, key_down 0, hold counter 0, rd_data 0x000.
- Reset mid-sequence discards any pending prefix and all buffered events.
- Latency: rx_valid of final byte at edge N -> event in FIFO, empty=0, rd_data valid, count incremented after edge N; last_code updated after the same edge.
- rd_data is FWFT: shows the head with no read latency; after a popping edge it shows the next entry or holds stale data with empty=1.
- count/full/empty are registered, updated on the same edge as the push/pop.
- Throughput: one event per cycle sustained; rx_valid may assert on consecutive cycles.
- Expiry: make at edge N, no further events -> last_code becomes 0x00 after edge N+HOLD_CYCLES.

## Test plan
- Reset, then rx bytes 0x1C -> rd_data=0x01C, count=1, last_code=0x1C; rd_en -> empty=1, count=0.
- Bytes E0,75 then E0,F0,75 -> two events 0x275 then 0x375; last_code 0x75 then 0x00 after the break.
- DEPTH=4: push 5 make codes without reads -> full=1, count=4, overflow=1, head still first code; ovf_clr -> overflow=0.
- full FIFO, push and rd_en same cycle -> count stays 4, overflow stays 0, new event at tail.
- HOLD_CYCLES=10: make 0x1C, idle -> last_code=0x1C for 10 cycles, 0x00 after; HOLD_CYCLES=0 -> never clears.
- Assert resetn low after 0xF0 only, release, send 0x1C -> event 0x01C (prefix lost), count=1.
